program_encoder: RTL and testbench

- Encodes structured instruction fields into 16-bit ISA words and streams them into program memory. It is the inverse of each core's instruction decoder.
- Sits between the host/loader side and the program memory write port. Used to load kernels before the dispatcher launches cores.
- Buffers encoded words in a small FIFO so field input and memory writes are decoupled.

---
 rtl/program_encoder.sv | 148 ++++++++++++++
 tb/tb_program_encoder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_encoder.sv
// Packs instruction field bundles into 16-bit ISA words and streams them through a
// small FIFO into program memory. Optional macro: PROGRAM_ENCODER_OVERFLOW_CHECK_EN.
module program_encoder #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_DEPTH         = 256,
    parameter int FIFO_DEPTH            = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] base_addr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [3:0]                       in_opcode,
    input  logic [3:0]                       in_rd,
    input  logic [3:0]                       in_rs,
    input  logic [3:0]                       in_rt,
    input  logic [2:0]                       in_nzp,
    input  logic [7:0]                       in_imm,
    input  logic                             in_last,
    output logic                             mem_write_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_write_address,
    output logic [15:0]                      mem_write_data,
    input  logic                             mem_write_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [PROGRAM_MEM_ADDR_BITS:0]   word_count
);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]                       state;
    logic [15:0]                      fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]              wr_ptr;
    logic [PTR_BITS-1:0]              rd_ptr;
    logic [PTR_BITS:0]                fifo_count;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr;

    logic fifo_empty, fifo_full, start_ok, accept, illegal, push, pop;
    logic write_fire, write_blocked;

    function automatic logic [15:0] encode(input logic [3:0] op, input logic [3:0] rd,
                                           input logic [3:0] rs, input logic [3:0] rt,
                                           input logic [2:0] nzp, input logic [7:0] imm);
        logic [15:0] word;
        case (op)
            4'b0001, 4'b1011:                   word = {op, nzp, 1'b0, imm};
            4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000:          word = {op, rd, rs, rt};
            4'b1001:                            word = {op, rd, imm};
            4'b1010:                            word = {op, rd, rs, nzp, 1'b0};
            default:                            word = {op, 12'h000};
        endcase
        return word;
    endfunction

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == (PTR_BITS+1)'(FIFO_DEPTH));
    assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
    assign in_ready   = (state == ST_ACCEPT) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign illegal    = (in_opcode == 4'b1101) || (in_opcode == 4'b1110);
    assign push       = accept && !illegal;

`ifdef PROGRAM_ENCODER_OVERFLOW_CHECK_EN
    localparam logic [PROGRAM_MEM_ADDR_BITS:0] DEPTH_LIMIT = (PROGRAM_MEM_ADDR_BITS+1)'(PROGRAM_DEPTH);
    logic addr_wrapped;

    // Once the address has wrapped or left the program, remaining words are dropped.
    assign write_blocked = !fifo_empty && (addr_wrapped || {1'b0, addr} >= DEPTH_LIMIT);
`else
    assign write_blocked = 1'b0;
`endif

    assign mem_write_valid   = !fifo_empty && !write_blocked;
    assign write_fire        = mem_write_valid && mem_write_ready;
    assign pop               = write_fire || write_blocked;
    assign mem_write_address = addr;
    // Gate the head so stale, never-reset storage never leaks onto the bus.
    assign mem_write_data    = mem_write_valid ? fifo_mem[rd_ptr] : 16'h0000;
    assign busy              = (state == ST_ACCEPT) || (state == ST_DRAIN);

    // NOTE: FIFO storage is deliberately not reset; the count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= encode(in_opcode, in_rd, in_rs, in_rt, in_nzp, in_imm);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            addr       <= '0;
            word_count <= '0;
            error      <= 1'b0;
            done       <= 1'b0;
`ifdef PROGRAM_ENCODER_OVERFLOW_CHECK_EN
            addr_wrapped <= 1'b0;
`endif
        end else begin
            case (state)
                ST_ACCEPT: if (accept && in_last) state <= ST_DRAIN;
                ST_DRAIN:  if (fifo_empty) begin
                               state <= ST_DONE;
                               done  <= 1'b1;
                           end
                default:   ;
            endcase

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase

            if (start_ok) begin
                state      <= ST_ACCEPT;
                addr       <= base_addr;
                word_count <= '0;
                error      <= 1'b0;
                done       <= 1'b0;
`ifdef PROGRAM_ENCODER_OVERFLOW_CHECK_EN
                addr_wrapped <= 1'b0;
`endif
            end else begin
                if (write_fire) begin
                    addr       <= addr + 1'b1;
                    word_count <= word_count + 1'b1;
`ifdef PROGRAM_ENCODER_OVERFLOW_CHECK_EN
                    if (&addr) addr_wrapped <= 1'b1;
`endif
                end
                if ((accept && illegal) || write_blocked) error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_encoder.sv
// Directed bench for program_encoder: reset, encodings, back-pressure, illegal opcodes,
// mid-session reset and address wrap (or overflow with PROGRAM_ENCODER_OVERFLOW_CHECK_EN).
module tb_program_encoder;
`ifdef PROGRAM_ENCODER_OVERFLOW_CHECK_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 256;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0;
    logic [2:0]  in_nzp = '0;
    logic [7:0]  in_imm = '0;
    logic        in_last = 1'b0;
    logic        mem_write_valid;
    logic [7:0]  mem_write_address;
    logic [15:0] mem_write_data;
    logic        mem_write_ready = 1'b1;
    logic        busy, done, error;
    logic [8:0]  word_count;

    int checks = 0;
    int failures = 0;
    logic [7:0]  log_addr [$];
    logic [15:0] log_data [$];

    program_encoder #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_DEPTH(DEPTH), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs(in_rs), .in_rt(in_rt), .in_nzp(in_nzp), .in_imm(in_imm), .in_last(in_last),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Inputs only change just after a rising edge, so the negedge view is what the next edge commits.
    always @(negedge clk) begin
        if (!reset && mem_write_valid && mem_write_ready) begin
            log_addr.push_back(mem_write_address);
            log_data.push_back(mem_write_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] base);
        log_addr.delete();
        log_data.delete();
        base_addr = base;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [2:0] nzp, input logic [7:0] imm,
                        input logic last);
        int waited;
        waited = 0;
        in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_nzp = nzp; in_imm = imm; in_last = last; in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            step();
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        while (done !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, waited);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({in_ready, mem_write_valid, busy, done, error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 00000", {in_ready, mem_write_valid, busy, done, error});
        end
        checks++;
        if ({mem_write_address, mem_write_data, word_count} !== 33'h0) begin
            failures++;
            $display("FAIL reset_values: addr=%h data=%h count=%h required all 0",
                     mem_write_address, mem_write_data, word_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        mem_write_ready = 1'b1;
        do_start(8'h10);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy: got %b required 1", busy);
        end
        send(4'b0011, 4'd1, 4'd2, 4'd3, 3'b000, 8'h00, 1'b1);
        wait_done();
        checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 8'h10 || log_data[0] !== 16'h3123) begin
            failures++;
            $display("FAIL single_write: n=%0d addr=%h data=%h required n=1 addr=10 data=3123",
                     log_addr.size(), log_addr.size() ? log_addr[0] : 8'hxx, log_data.size() ? log_data[0] : 16'hxxxx);
        end
        checks++;
        if ({busy, error, word_count} !== {1'b0, 1'b0, 9'd1}) begin
            failures++;
            $display("FAIL single_status: busy=%b error=%b count=%0d required 0 0 1", busy, error, word_count);
        end
    endtask

    task automatic test_sequence();
        logic [15:0] exp_data [3];
        exp_data[0] = 16'h1A2A;
        exp_data[1] = 16'hA456;
        exp_data[2] = 16'hF000;
        do_start(8'h20);
        send(4'b0001, 4'd7, 4'd7, 4'd7, 3'b101, 8'h2A, 1'b0);
        send(4'b1010, 4'd4, 4'd5, 4'd9, 3'b011, 8'hFF, 1'b0);
        send(4'b1111, 4'd3, 4'd3, 4'd3, 3'b111, 8'h55, 1'b1);
        wait_done();
        checks++;
        if (log_addr.size() != 3) begin
            failures++;
            $display("FAIL seq_count: got %0d writes required 3", log_addr.size());
        end
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 8'h20 + 8'(i) || log_data[i] !== exp_data[i]) begin
                failures++;
                $display("FAIL seq_write%0d: addr=%h data=%h required addr=%h data=%h",
                         i, log_addr[i], log_data[i], 8'h20 + 8'(i), exp_data[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_data [6];
        logic [7:0]  held_addr;
        logic [15:0] held_data;
        exp_data[0] = 16'h90C0; exp_data[1] = 16'h91C1; exp_data[2] = 16'h92C2;
        exp_data[3] = 16'h93C3; exp_data[4] = 16'h94C4; exp_data[5] = 16'h95C5;
        mem_write_ready = 1'b0;
        do_start(8'h40);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_ready_before_full: got %b required 1", in_ready);
                end
            end
            send(4'b1001, 4'(i), 4'hF, 4'hF, 3'b111, 8'hC0 + 8'(i), 1'b0);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_full: got %b required 0", in_ready);
        end
        held_addr = mem_write_address;
        held_data = mem_write_data;
        checks++;
        if (mem_write_valid !== 1'b1 || held_addr !== 8'h40 || held_data !== 16'h90C0) begin
            failures++;
            $display("FAIL bp_head: valid=%b addr=%h data=%h required 1 40 90C0", mem_write_valid, held_addr, held_data);
        end
        repeat (3) step();
        checks++;
        if (mem_write_valid !== 1'b1 || mem_write_address !== held_addr || mem_write_data !== held_data) begin
            failures++;
            $display("FAIL bp_stable: valid=%b addr=%h data=%h required 1 %h %h",
                     mem_write_valid, mem_write_address, mem_write_data, held_addr, held_data);
        end
        mem_write_ready = 1'b1;
        send(4'b1001, 4'd4, 4'hF, 4'hF, 3'b111, 8'hC4, 1'b0);
        send(4'b1001, 4'd5, 4'hF, 4'hF, 3'b111, 8'hC5, 1'b1);
        wait_done();
        checks++;
        if (log_addr.size() != 6 || word_count !== 9'd6) begin
            failures++;
            $display("FAIL bp_count: writes=%0d word_count=%0d required 6 6", log_addr.size(), word_count);
        end
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 8'h40 + 8'(i) || log_data[i] !== exp_data[i]) begin
                failures++;
                $display("FAIL bp_write%0d: addr=%h data=%h required addr=%h data=%h",
                         i, log_addr[i], log_data[i], 8'h40 + 8'(i), exp_data[i]);
            end
        end
    endtask

    task automatic test_illegal();
        do_start(8'h60);
        send(4'b1001, 4'd7, 4'd0, 4'd0, 3'b000, 8'h11, 1'b0);
        send(4'b1110, 4'd1, 4'd2, 4'd3, 3'b111, 8'hAA, 1'b0);
        send(4'b0100, 4'd2, 4'd3, 4'd4, 3'b000, 8'h00, 1'b1);
        wait_done();
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 8'h60 || log_data[0] !== 16'h9711 ||
            log_addr[1] !== 8'h61 || log_data[1] !== 16'h4234) begin
            failures++;
            $display("FAIL illegal_writes: n=%0d required 2 writes 60:9711 61:4234", log_addr.size());
        end
        checks++;
        if (error !== 1'b1 || word_count !== 9'd2) begin
            failures++;
            $display("FAIL illegal_error: error=%b count=%0d required 1 2", error, word_count);
        end
        do_start(8'h70);
        checks++;
        if ({error, done, busy} !== 3'b001) begin
            failures++;
            $display("FAIL illegal_restart: error/done/busy=%b required 001", {error, done, busy});
        end
        send(4'b1101, 4'd1, 4'd1, 4'd1, 3'b001, 8'h01, 1'b1);
        wait_done();
        checks++;
        if (log_addr.size() != 0 || error !== 1'b1 || word_count !== 9'd0 || mem_write_address !== 8'h70) begin
            failures++;
            $display("FAIL illegal_last: writes=%0d error=%b count=%0d addr=%h required 0 1 0 70",
                     log_addr.size(), error, word_count, mem_write_address);
        end
    endtask

    task automatic test_reset_mid();
        mem_write_ready = 1'b0;
        do_start(8'h80);
        for (int i = 0; i < 3; i++) send(4'b1001, 4'(i), 4'd0, 4'd0, 3'b000, 8'h30, 1'b0);
        checks++;
        if (mem_write_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_valid: got %b required 1", mem_write_valid);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({in_ready, mem_write_valid, busy, done, error, mem_write_address, mem_write_data, word_count} !== 38'h0) begin
            failures++;
            $display("FAIL rmid_outputs: valid=%b busy=%b addr=%h data=%h count=%0d required all 0",
                     mem_write_valid, busy, mem_write_address, mem_write_data, word_count);
        end
        reset = 1'b0;
        mem_write_ready = 1'b1;
        step();
        do_start(8'h90);
        send(4'b0011, 4'd5, 4'd6, 4'd7, 3'b000, 8'h00, 1'b1);
        wait_done();
        checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 8'h90 || log_data[0] !== 16'h3567 || word_count !== 9'd1) begin
            failures++;
            $display("FAIL rmid_reload: n=%0d count=%0d required one write 90:3567, count 1", log_addr.size(), word_count);
        end
    endtask

`ifdef PROGRAM_ENCODER_OVERFLOW_CHECK_EN
    task automatic test_overflow();
        mem_write_ready = 1'b1;
        do_start(8'h02);
        for (int i = 0; i < 3; i++) send(4'b0000, 4'hF, 4'hF, 4'hF, 3'b111, 8'hFF, i == 2);
        wait_done();
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 8'h02 || log_addr[1] !== 8'h03 ||
            log_data[0] !== 16'h0000 || log_data[1] !== 16'h0000) begin
            failures++;
            $display("FAIL ovf_writes: n=%0d required writes at 02 and 03 only", log_addr.size());
        end
        checks++;
        if (error !== 1'b1 || word_count !== 9'd2) begin
            failures++;
            $display("FAIL ovf_status: error=%b count=%0d required 1 2", error, word_count);
        end
    endtask
`else
    task automatic test_wrap();
        mem_write_ready = 1'b1;
        do_start(8'hFF);
        send(4'b1100, 4'hF, 4'hE, 4'hD, 3'b111, 8'hFF, 1'b0);
        send(4'b0000, 4'hF, 4'hF, 4'hF, 3'b111, 8'hFF, 1'b1);
        wait_done();
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 8'hFF || log_data[0] !== 16'hC000 ||
            log_addr[1] !== 8'h00 || log_data[1] !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_writes: n=%0d required FF:C000 then 00:0000", log_addr.size());
        end
        checks++;
        if (error !== 1'b0 || word_count !== 9'd2) begin
            failures++;
            $display("FAIL wrap_status: error=%b count=%0d required 0 2", error, word_count);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PROGRAM_ENCODER_OVERFLOW_CHECK_EN
        test_overflow();
`else
        test_single();
        test_sequence();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
